// File: rtl/tck_shift_scheduler_if.sv
// Requester/transmitter bus of the TCK shift scheduler. The master side is the scheduler,
// and the slave side is the TAP sources plus the TDO word transmitter.
interface tck_shift_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic                         shift_en;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0][31:0]     req_data;
  logic [NUM_REQ-1:0]           req_ack;
  logic [NUM_REQ-1:0]           req_abort;
  logic [NUM_REQ-1:0]           grant;
  logic                         tx_enable;
  logic [31:0]                  tx_data;
  logic                         tx_done;
  logic                         busy;
  logic                         timeout_err;
  logic [15:0]                  words_sent;

  modport master (
    input  shift_en, req_valid, req_data, tx_done,
    output req_ack, req_abort, grant, tx_enable, tx_data, busy, timeout_err, words_sent
  );

  modport slave (
    output shift_en, req_valid, req_data, tx_done,
    input  req_ack, req_abort, grant, tx_enable, tx_data, busy, timeout_err, words_sent
  );
endinterface

// File: rtl/tck_shift_scheduler.sv
// Round-robin arbiter that feeds one 32-bit word at a time to the TDO transmitter.
// It grants a requester, latches its word, and acks or aborts the requester when the transfer ends.
module tck_shift_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                    clk_tck,
  input  logic                    reset_n,
  tck_shift_scheduler_if.master   bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SHIFT, RELEASE} state_t;

  state_t                   state, state_nxt;
  logic [PW-1:0]            rr_ptr, rr_nxt, sel, sel_nxt, pick;
  logic [TW-1:0]            timer, timer_nxt;
  logic                     found;
  logic [NUM_REQ-1:0]       grant_q, grant_nxt, ack_q, ack_nxt, abort_q, abort_nxt, pick_oh;
  logic                     tx_en_q, tx_en_nxt, busy_q, busy_nxt, terr_q, terr_nxt;
  logic [31:0]              tx_data_q, tx_data_nxt;
  logic [15:0]              ws_q, ws_nxt;

  // The search runs in reverse, so the closest set index at or after rr_ptr is assigned last and wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[PW'((int'(rr_ptr) + i) % NUM_REQ)]) begin
        found = 1'b1;
        pick  = PW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr_ptr;
    sel_nxt     = sel;
    timer_nxt   = timer;
    grant_nxt   = grant_q;
    tx_en_nxt   = tx_en_q;
    tx_data_nxt = tx_data_q;
    busy_nxt    = busy_q;
    ack_nxt     = '0;
    abort_nxt   = '0;
    terr_nxt    = terr_q;
    ws_nxt      = ws_q;
    case (state)
      // RELEASE already holds tx_enable low for its one cycle, so its exit edge may grant
      // the next word. This gives the 34-cycle back-to-back spacing.
      IDLE, RELEASE: begin
        if (bus.shift_en && found) begin
          sel_nxt     = pick;
          grant_nxt   = pick_oh;
          tx_data_nxt = bus.req_data[pick];
          tx_en_nxt   = 1'b1;
          busy_nxt    = 1'b1;
          timer_nxt   = '0;
          state_nxt   = SHIFT;
        end else begin
          grant_nxt   = '0;
          tx_en_nxt   = 1'b0;
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end
      end
      SHIFT: begin
        timer_nxt = timer + TW'(1);
        if (!bus.shift_en || (!bus.tx_done && timer == TW'(TIMEOUT - 1))) begin
          abort_nxt = grant_q;
          grant_nxt = '0;
          tx_en_nxt = 1'b0;
          terr_nxt  = terr_q | bus.shift_en;
          state_nxt = RELEASE;
        end else if (bus.tx_done) begin
          ack_nxt   = grant_q;
          grant_nxt = '0;
          tx_en_nxt = 1'b0;
          ws_nxt    = ws_q + 16'd1;
          rr_nxt    = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + PW'(1);
          state_nxt = RELEASE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_tck or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      timer     <= '0;
      grant_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      ack_q     <= '0;
      abort_q   <= '0;
      terr_q    <= 1'b0;
      ws_q      <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      sel       <= sel_nxt;
      timer     <= timer_nxt;
      grant_q   <= grant_nxt;
      tx_en_q   <= tx_en_nxt;
      tx_data_q <= tx_data_nxt;
      busy_q    <= busy_nxt;
      ack_q     <= ack_nxt;
      abort_q   <= abort_nxt;
      terr_q    <= terr_nxt;
      ws_q      <= ws_nxt;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.tx_enable   = tx_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.req_ack     = ack_q;
  assign bus.req_abort   = abort_q;
  assign bus.timeout_err = terr_q;
  assign bus.words_sent  = ws_q;
endmodule

// File: tb/tb_tck_shift_scheduler.sv
// Bench for tck_shift_scheduler. The stimulus queues the grant/ack/abort events it expects,
// and a monitor pops and compares each event when it appears on the bus.
module tb_tck_shift_scheduler;
  localparam int EV_GRANT = 0, EV_ACK = 1, EV_ABORT = 2;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] word;
    bit          chk_word;
    int          gap;
  } ev_t;

  logic        clk_tck = 1'b0;
  logic        reset_n = 1'b0;
  logic        tie_low = 1'b0;
  logic        xmit_done = 1'b0;
  logic [31:0] tdo_word = '0;
  int          bit_cnt = 0;
  int          n_checks = 0, n_fail = 0, grants_seen = 0, g = 0;
  ev_t         sb[$];

  tck_shift_scheduler_if #(.NUM_REQ(4)) bus();

  tck_shift_scheduler #(.NUM_REQ(4), .TIMEOUT(40)) dut (
    .clk_tck (clk_tck),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_tck = ~clk_tck;

  // Transmitter model: MSB first on falling edges; done on the 33rd falling edge; re-arms while disabled.
  always @(negedge clk_tck) begin
    if (!bus.tx_enable) begin
      bit_cnt   <= 0;
      xmit_done <= 1'b0;
    end else if (bit_cnt < 32) begin
      tdo_word <= {tdo_word[30:0], bus.tx_data[31 - bit_cnt]};
      bit_cnt  <= bit_cnt + 1;
    end else begin
      xmit_done <= 1'b1;
    end
  end
  assign bus.tx_done = xmit_done & ~tie_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int idx, input logic [31:0] word, input bit cw, input int gap);
    ev_t e;
    e.kind = kind; e.idx = idx; e.word = word; e.chk_word = cw; e.gap = gap;
    sb.push_back(e);
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic score(input ev_t got);
    ev_t exp;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d idx %0d, expected none", got.kind, got.idx);
    end else begin
      exp = sb.pop_front();
      check("event_kind", 32'(got.kind), 32'(exp.kind));
      check("event_idx", 32'(got.idx), 32'(exp.idx));
      if (exp.chk_word) check("event_word", got.word, exp.word);
      if (exp.gap != 0) check("event_gap", 32'(got.gap), 32'(exp.gap));
    end
  endtask

  task automatic monitor();
    logic [3:0] prev_g;
    int cyc, last;
    ev_t got;
    prev_g = '0; cyc = 0; last = 0;
    forever begin
      @(posedge clk_tck); #2;
      cyc++;
      if (bus.grant != 0 && prev_g == 0) begin
        got.kind = EV_GRANT; got.idx = oh_idx(bus.grant); got.word = bus.tx_data;
        got.chk_word = 1'b1; got.gap = cyc - last;
        last = cyc;
        grants_seen++;
        score(got);
      end
      if (bus.req_ack != 0) begin
        got.kind = EV_ACK; got.idx = oh_idx(bus.req_ack); got.word = tdo_word;
        got.chk_word = 1'b1; got.gap = cyc - last;
        score(got);
      end
      if (bus.req_abort != 0) begin
        got.kind = EV_ABORT; got.idx = oh_idx(bus.req_abort); got.word = '0;
        got.chk_word = 1'b0; got.gap = cyc - last;
        score(got);
      end
      prev_g = bus.grant;
    end
  endtask

  task automatic wait_grants(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk_tck); #3;
      if (grants_seen >= n) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_grant: got %0d grants, expected %0d", grants_seen, n);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk_tck); #3;
      if (!bus.busy) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: busy got 1, expected 0");
  endtask

  initial begin
    bus.shift_en  = 1'b0;
    bus.req_valid = '0;
    bus.req_data[0] = 32'hA5A5_0000;
    bus.req_data[1] = 32'hDEAD_BEEF;
    bus.req_data[2] = 32'h0F0F_1234;
    bus.req_data[3] = 32'h8000_0001;
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk_tck);
    #1;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_tx_enable", 32'(bus.tx_enable), 32'h0);
    check("rst_tx_data", bus.tx_data, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_words", 32'(bus.words_sent), 32'h0);
    check("rst_terr", 32'(bus.timeout_err), 32'h0);
    @(negedge clk_tck) reset_n = 1'b1;

    // Single requester 1, 0xDEADBEEF
    @(posedge clk_tck); #1;
    push(EV_GRANT, 1, 32'hDEAD_BEEF, 1, 0);
    push(EV_ACK, 1, 32'hDEAD_BEEF, 1, 33);
    bus.shift_en  = 1'b1;
    bus.req_valid = 4'b0010;
    wait_grants(++g, 10);
    bus.req_valid = '0;
    repeat (33) @(posedge clk_tck);
    #3;
    check("t1_ack", 32'(bus.req_ack), 32'h2);
    check("t1_release_txen", 32'(bus.tx_enable), 32'h0);
    check("t1_release_busy", 32'(bus.busy), 32'h1);
    @(posedge clk_tck); #3;
    check("t1_ack_low", 32'(bus.req_ack), 32'h0);
    check("t1_idle_busy", 32'(bus.busy), 32'h0);
    check("t1_words", 32'(bus.words_sent), 32'h1);

    // Abort at E10 with requester 2 granted; requester 2 keeps priority
    push(EV_GRANT, 2, 32'h0F0F_1234, 1, 0);
    push(EV_ABORT, 2, 32'h0, 0, 10);
    bus.req_valid = 4'b0100;
    wait_grants(++g, 10);
    repeat (9) @(posedge clk_tck);
    #1 bus.shift_en = 1'b0;
    @(posedge clk_tck); #3;
    check("abort_pulse", 32'(bus.req_abort), 32'h4);
    check("abort_txen", 32'(bus.tx_enable), 32'h0);
    wait_idle(10);
    push(EV_GRANT, 2, 32'h0F0F_1234, 1, 0);
    push(EV_ACK, 2, 32'h0F0F_1234, 1, 33);
    bus.req_valid = 4'b1100;
    bus.shift_en  = 1'b1;
    wait_grants(++g, 10);
    bus.req_valid = '0;
    wait_idle(50);
    check("abort_words", 32'(bus.words_sent), 32'h2);

    // Reset at E15 with requester 3 granted, then all four requesters in round robin from 0
    push(EV_GRANT, 3, 32'h8000_0001, 1, 0);
    bus.req_valid = 4'b1000;
    wait_grants(++g, 10);
    repeat (15) @(posedge clk_tck);
    #1 reset_n = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    check("mid_rst_grant", 32'(bus.grant), 32'h0);
    check("mid_rst_txen", 32'(bus.tx_enable), 32'h0);
    check("mid_rst_busy", 32'(bus.busy), 32'h0);
    check("mid_rst_ackabort", 32'({bus.req_ack, bus.req_abort}), 32'h0);
    check("mid_rst_words", 32'(bus.words_sent), 32'h0);
    push(EV_GRANT, 0, 32'hA5A5_0000, 1, 0);  push(EV_ACK, 0, 32'hA5A5_0000, 1, 33);
    push(EV_GRANT, 1, 32'hDEAD_BEEF, 1, 34); push(EV_ACK, 1, 32'hDEAD_BEEF, 1, 33);
    push(EV_GRANT, 2, 32'h0F0F_1234, 1, 34); push(EV_ACK, 2, 32'h0F0F_1234, 1, 33);
    push(EV_GRANT, 3, 32'h8000_0001, 1, 34); push(EV_ACK, 3, 32'h8000_0001, 1, 33);
    push(EV_GRANT, 0, 32'hA5A5_0000, 1, 34); push(EV_ACK, 0, 32'hA5A5_0000, 1, 33);
    @(negedge clk_tck) reset_n = 1'b1;
    g += 5;
    wait_grants(g, 5 * 34 + 20);
    bus.req_valid = '0;
    wait_idle(50);
    check("rr_words", 32'(bus.words_sent), 32'h5);

    // tx_done tied low: timeout abort, and the sticky error survives a later good transfer
    tie_low = 1'b1;
    push(EV_GRANT, 1, 32'hDEAD_BEEF, 1, 0);
    push(EV_ABORT, 1, 32'h0, 0, 40);
    bus.req_valid = 4'b0010;
    wait_grants(++g, 10);
    bus.req_valid = '0;
    wait_idle(60);
    check("to_terr", 32'(bus.timeout_err), 32'h1);
    check("to_words", 32'(bus.words_sent), 32'h5);
    tie_low = 1'b0;
    push(EV_GRANT, 1, 32'hDEAD_BEEF, 1, 0);
    push(EV_ACK, 1, 32'hDEAD_BEEF, 1, 33);
    bus.req_valid = 4'b0010;
    wait_grants(++g, 10);
    bus.req_valid = '0;
    wait_idle(50);
    check("to_terr_sticky", 32'(bus.timeout_err), 32'h1);
    check("to_words_after", 32'(bus.words_sent), 32'h6);

    // Requester 2 changes its data and drops valid at E5; the latched word is still sent and acked
    push(EV_GRANT, 2, 32'h1234_5678, 1, 0);
    push(EV_ACK, 2, 32'h1234_5678, 1, 33);
    bus.req_data[2] = 32'h1234_5678;
    bus.req_valid   = 4'b0100;
    wait_grants(++g, 10);
    repeat (4) @(posedge clk_tck);
    #1;
    bus.req_data[2] = 32'hFFFF_FFFF;
    bus.req_valid   = '0;
    wait_idle(50);
    check("chg_words", 32'(bus.words_sent), 32'h7);

    repeat (3) @(posedge clk_tck);
    #3;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tck_shift_scheduler.md
# tck_shift_scheduler

Arbitrates up to NUM_REQ 32-bit data sources onto the single TDO word transmitter and sequences each transfer. Grants one requester at a time (round-robin), latches its word, and drives the transmitter's enable/data inputs. Watches the transmitter's done flag, then acknowledges the requester. Sits between the TAP data-register sources and the transmitter in the JTAG clock domain.

## Interface
- NUM_REQ, default 4: number of requesters, legal range 2..8.
- TIMEOUT, default 40: maximum cycles in SHIFT before a forced abort; must be ≥ 34.

- clk_tck  in  1  TCK; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- shift_en  in  1  TAP is in Shift-DR; transfers start and continue only while high.
- req_valid  in  NUM_REQ  per-requester request, level.
- req_data  in  32*NUM_REQ  requester i's word at bits [32*i+31:32*i].
- req_ack  out  NUM_REQ  one-cycle pulse to the granted requester on completion.
- req_abort  out  NUM_REQ  one-cycle pulse to the granted requester on abort.
- grant  out  NUM_REQ  one-hot owner of the current transfer; all zeros when idle.
- tx_enable  out  1  transmitter enable.
- tx_data  out  32  latched word presented to the transmitter.
- tx_done  in  1  transmitter done flag; updates on the falling edge.
- busy  out  1  high in SHIFT and RELEASE.
- timeout_err  out  1  sticky; set on timeout abort, cleared only by reset.
- words_sent  out  16  count of acked transfers; wraps 0xFFFF→0.

## Operation
- States: IDLE, SHIFT, RELEASE. Reset state is IDLE.
- Reset values: all outputs 0, rr_ptr=0, timer=0.
- IDLE:
  - If shift_en=1 and any req_valid bit is set, select the first set index searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Register grant, tx_data=req_data[sel], tx_enable=1, busy=1, timer=0, then go to SHIFT.
  - Otherwise hold all outputs at 0.
- SHIFT: timer increments each cycle. Conditions are evaluated in priority order:
  - 1. shift_en=0 → abort: pulse req_abort[sel], grant=0, tx_enable=0, rr_ptr unchanged (the aborted requester keeps priority), go to RELEASE.
  - 2. tx_done=1 → complete: pulse req_ack[sel], grant=0, tx_enable=0, words_sent+1, rr_ptr=(sel+1) mod NUM_REQ, go to RELEASE.
  - 3. timer=TIMEOUT-1 → abort as in rule 1, and also set timeout_err.
- RELEASE: tx_enable stays 0 for exactly one cycle so the transmitter re-arms its bit counter and clears done. busy=0 on exit, then go to IDLE.
- tx_data is held from grant until the next grant. Requester changes to req_data or req_valid after grant are ignored.
- A requester that drops req_valid mid-transfer still receives its ack.
- The transmitter emits tx_data MSB first, one bit per falling edge.
- Reset asserted mid-transfer: outputs go to 0 immediately and no ack or abort pulse is issued.

## Timing
- Edge numbering: E0 is the rising edge where IDLE samples a request. E+n is n rising edges later.
- E0: grant, tx_data and tx_enable become valid.
- Transmitter: bit 31 on the falling edge after E0, bit 0 on the 32nd falling edge, done on the 33rd falling edge.
- Ack: req_ack is high for the cycle after E33 and is low again after E34.
- RELEASE occupies the E33→E34 cycle; IDLE can grant again at E34.
- Back-to-back throughput: one word per 34 cycles.
- tx_done is sampled on the rising edge, half a cycle after the transmitter drives it; no synchronizer is needed (same clock).
- Simultaneous events at one edge: shift_en falling together with tx_done rising gives an abort, because abort wins.

## Test plan
- Single requester 1 with word 0xDEADBEEF and shift_en held high:
  - grant=0b0010 at E0;
  - TDO sequence 1,1,0,1,… (MSB first);
  - req_ack[1] pulses after E33;
  - words_sent=1; tx_enable low for one cycle.
- All four requesters valid continuously: grants cycle 0,1,2,3,0 at 34-cycle spacing, with no requester skipped.
- shift_en dropped at E10 with requester 2 granted:
  - req_abort[2] pulses and tx_enable=0;
  - the next grant (shift_en high, req 2 and 3 valid) goes to requester 2.
- tx_done tied low: abort after TIMEOUT cycles, timeout_err=1 and stays 1 through later successful transfers.
- reset_n pulsed low at E15 mid-transfer: all outputs 0 asynchronously, no ack or abort pulse, first grant after release goes to requester 0.
- req_data changed and req_valid dropped at E5: TDO still shows the word latched at E0 and the ack is still issued.
